// File: rtl/frontend_issue_queue.sv
// Fetch-to-decode issue queue: compacting storage, one issue per cycle, with optional
// hoisting of an independent younger branch or load from the oldest WINDOW entries.
module frontend_issue_queue #(
    parameter int DEPTH    = 4,
    parameter int WINDOW   = 2,
    parameter bit HOIST_EN = 1'b1,
    parameter bit DROP_NOP = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    input  logic [31:0]                i_in_pc,
    input  logic [31:0]                i_in_instr,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic [31:0]                o_out_pc,
    output logic [31:0]                o_out_instr,
    output logic                       o_out_hoist,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = $clog2(DEPTH);

    typedef struct packed {
        logic        br;
        logic        lw;
        logic [30:0] rm;
        logic [30:0] wm;
    } traits_t;

    // Register masks cover regs 1..31; $0 never creates a dependency.
    function automatic logic [30:0] regbit(input logic [4:0] r);
        return (r == 5'd0) ? 31'd0 : (31'd1 << (r - 5'd1));
    endfunction

    function automatic traits_t decode(input logic [5:0] op, input logic [4:0] rs, rt, rd,
                                       input logic [5:0] fn);
        traits_t t;
        t = '0;
        case (op)
            6'h00: begin
                if (fn == 6'h08 || fn == 6'h09) begin
                    t.br = 1'b1;
                    t.rm = regbit(rs);
                    t.wm = (fn == 6'h09) ? regbit(rd) : 31'd0;
                end else begin
                    t.rm = regbit(rs) | regbit(rt);
                    t.wm = regbit(rd);
                end
            end
            6'h01, 6'h06, 6'h07: begin t.br = 1'b1; t.rm = regbit(rs); end
            6'h02: t.br = 1'b1;
            6'h03: begin t.br = 1'b1; t.wm = regbit(5'd31); end
            6'h04, 6'h05: begin t.br = 1'b1; t.rm = regbit(rs) | regbit(rt); end
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e: begin
                t.rm = regbit(rs);
                t.wm = regbit(rt);
            end
            6'h0f: t.wm = regbit(rt);
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
                t.rm = regbit(rs);
                t.wm = regbit(rt);
                t.lw = (op == 6'h23);
            end
            6'h28, 6'h29, 6'h2a, 6'h2b, 6'h2e: t.rm = regbit(rs) | regbit(rt);
            default: ;
        endcase
        return t;
    endfunction

    logic [31:0]   r_pc    [DEPTH];
    logic [31:0]   r_instr [DEPTH];
    logic [CW-1:0] r_count;
    logic          r_slot_lock;

    traits_t       w_tr [DEPTH];
    logic [SW-1:0] w_sel;
    logic [SW-1:0] w_wr_idx;
    logic [CW-1:0] w_lim;
    logic          w_enq;
    logic          w_deq;

    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            w_tr[i] = decode(r_instr[i][31:26], r_instr[i][25:21], r_instr[i][20:16],
                             r_instr[i][15:11], r_instr[i][5:0]);
    end

    // Lowest eligible younger entry wins; a branch at entry 0 or a pending delay slot pins sel to 0.
    always_comb begin
        logic w_found;
        logic w_cand;
        logic w_ok;
        w_sel   = '0;
        w_found = 1'b0;
        w_cand  = 1'b0;
        w_ok    = 1'b0;
        w_lim   = (r_count < CW'(WINDOW)) ? r_count : CW'(WINDOW);
        if (HOIST_EN && !r_slot_lock && !w_tr[0].br) begin
            for (int j = 1; j < DEPTH; j++) begin
                w_cand = (CW'(j) < w_lim) &&
                         ((w_tr[j].br && j == 1) || (w_tr[j].lw && !w_tr[0].lw));
                w_ok = 1'b1;
                for (int k = 0; k < j; k++) begin
                    if (w_tr[k].br)
                        w_ok = 1'b0;
                    if (((w_tr[j].wm & (w_tr[k].rm | w_tr[k].wm)) |
                         (w_tr[k].wm & (w_tr[j].rm | w_tr[j].wm))) != 31'd0)
                        w_ok = 1'b0;
                end
                if (w_cand && w_ok && !w_found) begin
                    w_sel   = SW'(j);
                    w_found = 1'b1;
                end
            end
        end
    end

    assign o_in_ready  = (r_count < CW'(DEPTH));
    assign o_out_valid = (r_count != '0);
    assign o_out_pc    = r_pc[w_sel];
    assign o_out_instr = r_instr[w_sel];
    assign o_out_hoist = (w_sel != '0) && o_out_valid;
    assign o_count     = r_count;

    assign w_deq    = o_out_valid && i_out_ready;
    assign w_enq    = i_in_valid && o_in_ready && !(DROP_NOP && (i_in_instr == 32'd0));
    assign w_wr_idx = SW'(r_count - CW'(w_deq));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
            end
            r_count     <= '0;
            r_slot_lock <= 1'b0;
        end else if (i_flush) begin
            r_count     <= '0;
            r_slot_lock <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                if (w_deq && SW'(i) >= w_sel) begin
                    r_pc[i]    <= r_pc[i+1];
                    r_instr[i] <= r_instr[i+1];
                end
            end
            if (w_enq) begin
                r_pc[w_wr_idx]    <= i_in_pc;
                r_instr[w_wr_idx] <= i_in_instr;
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            if (w_deq)
                r_slot_lock <= w_tr[w_sel].br;
        end
    end
endmodule
